// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory arbiter slice.
// Holds the FSM/owner enums, memory geometry defaults and a saturating-increment helper.
package cpu_pkg;

  localparam int MEM_AW = 5;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {IDLE, ACC, RSP} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the arbiter.
// slave = arbiter side, master = requesters plus memory instance.
interface mem_arbiter_if #(
  parameter int AW = cpu_pkg::MEM_AW,
  parameter int DW = cpu_pkg::MEM_DW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid,
    output rdata,
    output mem_rd, mem_wr, mem_add, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid,
    input  rdata,
    input  mem_rd, mem_wr, mem_add, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of arbitration points the debug port lost to the CPU.
// full forces the next debug request through ahead of the CPU.
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);

  logic [CW-1:0] cnt_reg;

  assign full = (cnt_reg == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !full) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port program/data memory (CPU priority, debug anti-starvation and lock).
// Optional performance counters are built when MEM_ARBITER_PERF_CNT_EN is defined.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = MEM_AW,
  parameter int DW       = MEM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_PERF_CNT_EN
  ,
  input  logic          perf_clr,
  output logic [15:0]   cpu_acc_cnt,
  output logic [15:0]   dbg_acc_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  arb_state_t    state_reg, state_next;
  owner_t        owner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          locked_reg;

  logic arb_point, lock_hold, wait_full;
  logic cpu_win, dbg_win, starve_inc;
  logic cpu_gnt_w, dbg_gnt_w, rd_rsp;

  assign arb_point  = (state_reg == IDLE) || (state_reg == RSP);
  // Lock only survives an arbitration point while dbg_lock is still high.
  assign lock_hold  = locked_reg && bus.dbg_lock;
  assign starve_inc = cpu_win && bus.dbg_req;

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (arb_point) begin
      if (lock_hold) begin
        dbg_win = bus.dbg_req;
      end else if (wait_full && bus.dbg_req) begin
        dbg_win = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_win = 1'b1;
      end else if (bus.dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (4)
  ) u_starve (
    .clk  (clk),
    .rst  (rst),
    .inc  (starve_inc),
    .clr  (dbg_win),
    .full (wait_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RSP: state_next = (cpu_win || dbg_win) ? ACC : IDLE;
      ACC:       state_next = RSP;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg  <= OWN_CPU;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      locked_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (cpu_win) begin
        owner_reg <= OWN_CPU;
        we_reg    <= bus.cpu_we;
        addr_reg  <= bus.cpu_addr;
        wdata_reg <= bus.cpu_wdata;
      end else if (dbg_win) begin
        owner_reg <= OWN_DBG;
        we_reg    <= bus.dbg_we;
        addr_reg  <= bus.dbg_addr;
        wdata_reg <= bus.dbg_wdata;
      end
      if (arb_point) begin
        locked_reg <= dbg_win ? bus.dbg_lock : lock_hold;
      end
      if (rd_rsp) begin
        rdata_reg <= bus.mem_dout;
      end
    end
  end

  // Outputs decode from registered state so an async reset clears them at once.
  always_comb begin
    cpu_gnt_w      = (state_reg == ACC) && (owner_reg == OWN_CPU);
    dbg_gnt_w      = (state_reg == ACC) && (owner_reg == OWN_DBG);
    rd_rsp         = (state_reg == RSP) && !we_reg;
    bus.cpu_gnt    = cpu_gnt_w;
    bus.dbg_gnt    = dbg_gnt_w;
    bus.mem_rd     = (state_reg == ACC) && !we_reg;
    bus.mem_wr     = (state_reg == ACC) && we_reg;
    bus.mem_add    = (state_reg == ACC) ? addr_reg : '0;
    bus.mem_din    = ((state_reg == ACC) && we_reg) ? wdata_reg : '0;
    bus.cpu_rvalid = rd_rsp && (owner_reg == OWN_CPU);
    bus.dbg_rvalid = rd_rsp && (owner_reg == OWN_DBG);
    bus.rdata      = rd_rsp ? bus.mem_dout : rdata_reg;
  end

`ifdef MEM_ARBITER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_acc_cnt <= '0;
      dbg_acc_cnt <= '0;
      stall_cnt   <= '0;
    end else if (perf_clr) begin
      cpu_acc_cnt <= '0;
      dbg_acc_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (cpu_gnt_w) cpu_acc_cnt <= sat_inc16(cpu_acc_cnt);
      if (dbg_gnt_w) dbg_acc_cnt <= sat_inc16(dbg_acc_cnt);
      if (bus.cpu_req && !cpu_gnt_w) stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule
